mem_sram_ctrl: RTL and testbench
================================

Name: mem_sram_ctrl

Overview:
- Word-addressed synchronous memory that sits directly downstream of the AXI4-Lite-to-memory bridge, as the slave end of mem_if.
- One write port and one read port; a fixed, parameterised read latency, fully pipelined.
- Optional zero-clear of the whole array after reset, run by a small FSM.
- The bridge has no back-pressure path, so this block never stalls; it drops requests during clear and flags them.

Parameters:
- ALEN, 10, word-address width; array depth 2**ALEN.
- DLEN, 32, data width in bits (multiple of 8).
- RD_LAT, 1, cycles from ren to rvalid; legal range 1..4; elaboration error outside that range.
- CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = go straight to RUN with contents undefined.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- wen  in  1  write enable, single-cycle pulse per write
- waddr  in  ALEN  write word address
- wdata  in  DLEN  write data (bridge has already applied strobes)
- ren  in  1  read enable, single-cycle pulse per read
- raddr  in  ALEN  read word address
- rvalid  out  1  read data valid, exactly one pulse per accepted ren
- rdata  out  DLEN  read data, valid only while rvalid=1
- init_done  out  1  high once the array is usable (RUN state)
- drop_err  out  1  sticky; set when any wen or ren arrives while in INIT

Behaviour:
- Reset (rstn=0 at posedge):
  - FSM goes to INIT if CLEAR_ON_RESET=1, else RUN.
  - clr_addr=0; all read-pipeline valids=0.
  - rvalid=0, rdata=0, init_done=0 (1 if CLEAR_ON_RESET=0), drop_err=0.
  - Array contents are not touched by reset itself.
- FSM INIT:
  - Each cycle writes 0 to array[clr_addr], then clr_addr+1.
  - When clr_addr is all-ones, that write completes, then RUN on the next cycle.
  - INIT lasts exactly 2**ALEN cycles after reset release; init_done rises in the first RUN cycle.
- FSM RUN: terminal state; only reset leaves it.
- Requests during INIT:
  - wen is dropped (no array write) and drop_err is set.
  - ren still yields an rvalid pulse RD_LAT cycles later with rdata=0, and drop_err is set.
  - This keeps the bridge's rvalid/arready handshake alive.
- Write (RUN):
  - wen=1 at posedge E writes array[waddr]=wdata at E.
  - No response is produced; bresp is generated by the bridge.
- Read (RUN):
  - ren=1 at posedge E samples array[raddr] at E.
  - rvalid=1 and rdata=sample during the cycle after edge E+RD_LAT-1, i.e. RD_LAT cycles later; RD_LAT=1 gives rvalid in the cycle after ren.
  - Back-to-back reads every cycle are accepted; rvalid pulses follow in the same order.
- Read-during-write, same address, same edge: write-first; the read returns the new wdata.
- A write after the sampling edge does not alter an in-flight read, even at the same address.
- rdata holds its last value when rvalid=0 (no reset of the data path beyond rdata=0).
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid is emitted for them.
  - INIT restarts from clr_addr=0.
  - drop_err clears.
- Simultaneous wen and ren to different addresses: both are serviced independently.

Decomposition:
- Package mem_pkg:
  - state enum mem_state_e {MEM_INIT, MEM_RUN}
  - localparam RD_LAT_MAX=4
  - localparam bit [1:0] OKAY/SLVERR encodings, shared with the bridge
- Sub-module mem_rd_pipe:
  - RD_LAT-deep shift register of {valid, data}, reset clears the valids.
  - Instantiated once for the read return path.

Test Plan:
- ALEN=4, CLEAR_ON_RESET=1: release reset, preload nothing -> init_done rises exactly 16 cycles after release; reads of addr 0..15 all return 0x0000_0000.
- RUN, RD_LAT=1: write 0xDEADBEEF to addr 3, then ren addr 3 on the next cycle -> rvalid exactly 1 cycle after ren, rdata=0xDEADBEEF.
- RD_LAT=3: ren on 4 consecutive cycles, addrs 1,2,3,4 holding 0x11,0x22,0x33,0x44 -> 4 consecutive rvalid pulses starting 3 cycles after the first ren, data in order 0x11,0x22,0x33,0x44.
- Same-edge wen/ren to addr 5 (old 0xAAAA, new 0x5555) -> rdata=0x5555; a write to addr 5 one cycle after ren with RD_LAT=3 -> read still returns the sampled value.
- During INIT: pulse wen (addr 2, 0xFF) and ren (addr 2) -> drop_err=1, rvalid after RD_LAT with rdata=0; after init_done, read addr 2 returns 0.
- Reset asserted with 2 reads in flight (RD_LAT=4) -> no rvalid follows; INIT restarts and init_done=0 until 2**ALEN cycles after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM controller sitting below the AXI4-Lite bridge.
// The response encodings are kept here so both ends of mem_if agree on them.
package mem_pkg;

   typedef enum logic [0:0] {
      MEM_INIT = 1'b0,
      MEM_RUN  = 1'b1
   } mem_state_e;

   localparam int RD_LAT_MAX = 4;

   localparam bit [1:0] OKAY   = 2'b00;
   localparam bit [1:0] SLVERR = 2'b10;

   // Observable controller state: FSM state plus the sticky drop flag.
   typedef struct packed {
      logic [0:0] state;
      logic       drop_err;
   } mem_ctrl_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency read return path: LAT-deep shift register of {valid, data}.
// Data stages only load behind a valid, so the output holds its last value between pulses.
module mem_rd_pipe #(
   parameter int DLEN = 32,
   parameter int LAT  = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid_i,
   input  logic [DLEN-1:0] in_data_i,
   output logic            out_valid_o,
   output logic [DLEN-1:0] out_data_o
);

   logic [LAT-1:0]           valid_q;
   logic [LAT-1:0][DLEN-1:0] data_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q[0] <= in_valid_i;
         if (in_valid_i) data_q[0] <= in_data_i;
         for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign out_valid_o = valid_q[LAT-1];
   assign out_data_o  = data_q[LAT-1];

endmodule

// File: rtl/mem_sram_ctrl.sv
// Word-addressed single-write/single-read SRAM with a pipelined fixed read latency
// and an optional post-reset zero-clear. It never stalls: requests seen during clear are dropped and flagged.
module mem_sram_ctrl
   import mem_pkg::*;
#(
   parameter int ALEN           = 10,
   parameter int DLEN           = 32,
   parameter int RD_LAT         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            wen,
   input  logic [ALEN-1:0] waddr,
   input  logic [DLEN-1:0] wdata,
   input  logic            ren,
   input  logic [ALEN-1:0] raddr,
   output logic            rvalid,
   output logic [DLEN-1:0] rdata,
   output logic            init_done,
   output logic            drop_err
);

   localparam int         DEPTH   = 1 << ALEN;
   localparam logic [0:0] ST_INIT = MEM_INIT;
   localparam logic [0:0] ST_RUN  = MEM_RUN;

   if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("mem_sram_ctrl: RD_LAT must be in 1..%0d", RD_LAT_MAX);
   end
   if (DLEN % 8 != 0) begin : g_bad_dlen
      $error("mem_sram_ctrl: DLEN must be a multiple of 8");
   end

   // Valid/ready contract: there is no ready. Every wen/ren pulse is taken on the edge it is
   // seen; each ren yields exactly one rvalid pulse RD_LAT cycles later, in issue order.

   mem_ctrl_t        ctrl_q, ctrl_d;
   logic [ALEN-1:0]  clr_addr_q, clr_addr_d;
   logic [DLEN-1:0]  mem_q [DEPTH];
   logic             in_init;
   logic [DLEN-1:0]  rd_sample;

   assign in_init = (ctrl_q.state == ST_INIT);

   always_comb begin
      ctrl_d     = ctrl_q;
      clr_addr_d = clr_addr_q;
      if (in_init) begin
         clr_addr_d = clr_addr_q + ALEN'(1);
         if (&clr_addr_q) ctrl_d.state = ST_RUN;
         if (wen || ren) ctrl_d.drop_err = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ctrl_q.state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
         ctrl_q.drop_err <= 1'b0;
         clr_addr_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // The array itself is never reset; the clear sweep owns the write port during INIT.
   always_ff @(posedge clk) begin
      if (rstn) begin
         if (in_init) mem_q[clr_addr_q] <= '0;
         else if (wen) mem_q[waddr] <= wdata;
      end
   end

   // Write-first on a same-edge collision; reads during INIT return zero.
   always_comb begin
      rd_sample = '0;
      if (!in_init) begin
         if (wen && (waddr == raddr)) rd_sample = wdata;
         else                         rd_sample = mem_q[raddr];
      end
   end

   mem_rd_pipe #(
      .DLEN (DLEN),
      .LAT  (RD_LAT)
   ) u_rd_pipe (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid_i  (ren),
      .in_data_i   (rd_sample),
      .out_valid_o (rvalid),
      .out_data_o  (rdata)
   );

   assign init_done = (ctrl_q.state == ST_RUN);
   assign drop_err  = ctrl_q.drop_err;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: two instances (RD_LAT=3 and RD_LAT=1) share one stimulus stream
// and are compared every cycle against a reference memory with per-instance return queues.
module tb_mem_sram_ctrl;

   localparam int ALEN  = 4;
   localparam int DLEN  = 32;
   localparam int DEPTH = 16;
   localparam int LAT_A = 3;
   localparam int LAT_B = 1;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic            wen   = 1'b0;
   logic            ren   = 1'b0;
   logic [ALEN-1:0] waddr = '0;
   logic [ALEN-1:0] raddr = '0;
   logic [DLEN-1:0] wdata = '0;

   logic            rvalid_a, init_done_a, drop_err_a;
   logic [DLEN-1:0] rdata_a;
   logic            rvalid_b, init_done_b, drop_err_b;
   logic [DLEN-1:0] rdata_b;

   mem_sram_ctrl #(.ALEN(ALEN), .DLEN(DLEN), .RD_LAT(LAT_A), .CLEAR_ON_RESET(1)) u_dut_a (
      .clk(clk), .rstn(rstn), .wen(wen), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rvalid(rvalid_a), .rdata(rdata_a),
      .init_done(init_done_a), .drop_err(drop_err_a)
   );

   mem_sram_ctrl #(.ALEN(ALEN), .DLEN(DLEN), .RD_LAT(LAT_B), .CLEAR_ON_RESET(1)) u_dut_b (
      .clk(clk), .rstn(rstn), .wen(wen), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rvalid(rvalid_b), .rdata(rdata_b),
      .init_done(init_done_b), .drop_err(drop_err_b)
   );

   // ---------------- reference model / scoreboard ----------------
   int              tests = 0;
   int              fails = 0;
   logic [DLEN-1:0] ref_mem [DEPTH];
   int              edge_no = 0;
   int              rel_cnt = 0;
   logic            drop_m  = 1'b0;
   logic [DLEN-1:0] exp_q_a [$];
   logic [DLEN-1:0] exp_q_b [$];
   int              due_q_a [$];
   int              due_q_b [$];
   logic [DLEN-1:0] hold_a = '0;
   logic [DLEN-1:0] hold_b = '0;

   task automatic chk(input string tag, input logic [DLEN-1:0] obs, input logic [DLEN-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Cleared array is modelled as all-zero from the moment INIT starts: reads during INIT
   // return zero and writes are dropped, so the end state is identical.
   task automatic model_edge();
      logic            init;
      logic [DLEN-1:0] d;
      edge_no++;
      if (!rstn) begin
         exp_q_a.delete(); due_q_a.delete();
         exp_q_b.delete(); due_q_b.delete();
         hold_a  = '0;
         hold_b  = '0;
         rel_cnt = 0;
         drop_m  = 1'b0;
         foreach (ref_mem[i]) ref_mem[i] = '0;
      end else begin
         init = (rel_cnt < DEPTH);
         if (init && (wen || ren)) drop_m = 1'b1;
         if (init)                              d = '0;
         else if (wen && (waddr == raddr))      d = wdata;
         else                                   d = ref_mem[raddr];
         if (ren) begin
            exp_q_a.push_back(d); due_q_a.push_back(edge_no + LAT_A - 1);
            exp_q_b.push_back(d); due_q_b.push_back(edge_no + LAT_B - 1);
         end
         if (!init && wen) ref_mem[waddr] = wdata;
         if (rel_cnt < DEPTH) rel_cnt++;
      end
   endtask

   task automatic chk_rd_a();
      logic ev;
      ev = (due_q_a.size() > 0) && (due_q_a[0] == edge_no);
      chk("rvalid_a", 32'(rvalid_a), 32'(ev));
      if (ev) begin
         hold_a = exp_q_a.pop_front();
         void'(due_q_a.pop_front());
      end
      chk("rdata_a", rdata_a, hold_a);
   endtask

   task automatic chk_rd_b();
      logic ev;
      ev = (due_q_b.size() > 0) && (due_q_b[0] == edge_no);
      chk("rvalid_b", 32'(rvalid_b), 32'(ev));
      if (ev) begin
         hold_b = exp_q_b.pop_front();
         void'(due_q_b.pop_front());
      end
      chk("rdata_b", rdata_b, hold_b);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic w, input logic [ALEN-1:0] wa, input logic [DLEN-1:0] wd,
                       input logic r, input logic [ALEN-1:0] ra);
      wen = w; waddr = wa; wdata = wd; ren = r; raddr = ra;
      @(posedge clk);
      model_edge();
      #1;
      chk_rd_a();
      chk_rd_b();
      chk("init_done_a", 32'(init_done_a), 32'(rel_cnt >= DEPTH));
      chk("init_done_b", 32'(init_done_b), 32'(rel_cnt >= DEPTH));
      chk("drop_err_a", 32'(drop_err_a), 32'(drop_m));
      chk("drop_err_b", 32'(drop_err_b), 32'(drop_m));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic wr(input logic [ALEN-1:0] a, input logic [DLEN-1:0] d);
      step(1'b1, a, d, 1'b0, '0);
   endtask

   task automatic rd(input logic [ALEN-1:0] a);
      step(1'b0, '0, '0, 1'b1, a);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rstn = 1'b0;
      idle(3);
      rstn = 1'b1;

      // Requests during INIT are dropped/flagged; the read still returns zero.
      idle(3);
      step(1'b1, 4'd2, 32'h0000_00FF, 1'b1, 4'd2);
      idle(14);

      // Clear sweep leaves every word zero.
      for (int a = 0; a < DEPTH; a++) rd(4'(a));
      idle(4);

      wr(4'd3, 32'hDEAD_BEEF);
      rd(4'd3);
      idle(4);

      wr(4'd1, 32'h11); wr(4'd2, 32'h22); wr(4'd3, 32'h33); wr(4'd4, 32'h44);
      rd(4'd1); rd(4'd2); rd(4'd3); rd(4'd4);
      idle(4);

      // Same-edge collision is write-first; a later write leaves an in-flight read alone.
      wr(4'd5, 32'h0000_AAAA);
      step(1'b1, 4'd5, 32'h0000_5555, 1'b1, 4'd5);
      rd(4'd5);
      wr(4'd5, 32'h0000_1234);
      idle(4);
      rd(4'd5);
      idle(4);

      // Concurrent write and read to different addresses.
      step(1'b1, 4'd7, 32'hCAFE_F00D, 1'b1, 4'd4);
      rd(4'd7);
      idle(4);

      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), $urandom,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)));
      idle(4);

      // Reset with reads in flight: nothing returns, INIT restarts, drop_err clears.
      rd(4'd3); rd(4'd4);
      rstn = 1'b0;
      idle(1);
      rstn = 1'b1;
      idle(5);
      for (int i = 0; i < 40; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), $urandom,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)));
      for (int a = 0; a < DEPTH; a++) rd(4'(a));
      idle(6);

      tests++;
      assert ((exp_q_a.size() + exp_q_b.size()) == 0) else begin
         fails++;
         $error("FAIL pending_reads: got %0d, expected 0", exp_q_a.size() + exp_q_b.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
